mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for MUL/MLA in the EXE stage. It time-shares the existing 32-bit EXE ALU adder path (exe_cmd 4'b0010) to run a radix-2 shift-and-add multiply.
- Sits between the forwarding muxes and the ALU inputs. When idle it passes the normal EXE operands straight through; when busy it overrides them and stalls the pipeline.
- Delivers a 32-bit product plus N/Z flags for writeback and the status register.

Parameters:
- W, 32, datapath width (ALU width; fixed at 32 in this design)
- CNT_W, 6, iteration counter width (must hold W)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  MUL/MLA present in EXE; sampled only in IDLE
- is_mla  input  1  1 = MLA (accumulate acc_in), 0 = MUL
- op_a  input  32  multiplicand (forwarded Rm)
- op_b  input  32  multiplier (forwarded Rs)
- acc_in  input  32  accumulate operand (forwarded Rn)
- val1_in  input  32  normal ALU in1 from forwarding mux
- val2_in  input  32  normal ALU in2 from val2 path
- cmd_in  input  4  normal exe_cmd
- status_in  input  4  current {N,Z,C,V} from status register
- alu_result  input  32  result from shared ALU
- alu_in1  output  32  ALU in1 (muxed)
- alu_in2  output  32  ALU in2 (muxed)
- alu_cmd  output  4  ALU exe_cmd (muxed)
- stall  output  1  freeze IF/ID/EX pipeline registers
- done  output  1  one-cycle pulse: product valid
- mul_result  output  32  product, low 32 bits
- status_out  output  4  {N,Z,C,V} for the completed multiply

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. Internal acc, mcand, mplier and cnt cleared. Registered outputs done=0 and mul_result=0. Reset mid-operation aborts silently; no done pulse follows.
- States: IDLE, ITER, DONE.
- IDLE:
  - Pass-through: alu_in1=val1_in, alu_in2=val2_in, alu_cmd=cmd_in.
  - stall=start (combinational).
  - On start at edge T: acc<=is_mla?acc_in:0, mcand<=op_a, mplier<=op_b, cnt<=0.
  - Next state is ITER, or DONE under early termination (see Optional Feature).
- ITER:
  - Override: alu_in1=acc, alu_in2=mplier[0]?mcand:0, alu_cmd=4'b0010. stall=1.
  - Each edge: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Exit to DONE after the edge where cnt==W-1 (W iterations total).
- DONE:
  - mul_result=acc and done=1 for exactly one cycle. stall=0, so the pipeline advances and captures the result. Next state is IDLE.
- Outputs in DONE:
  - Pass-through muxing is restored.
  - status_out={acc[31], acc==0, status_in[2], status_in[1]}: MUL/MLA update N,Z only; C,V are preserved.
- Arithmetic: all operations are modulo 2^32. Carry and overflow from the ALU are ignored. Operands are treated as unsigned (low 32 bits are identical for signed operands).
- Latency (feature off): start seen at edge T, done high in cycle T+W+1 (T+33). stall is high from cycle T through T+W inclusive.
- start while in ITER or DONE is ignored. The pipeline is stalled during ITER, so a second start cannot be in flight legitimately.
- Operands are captured at edge T. Later changes to op_a, op_b or acc_in during ITER have no effect.
- When not in DONE, done=0 and mul_result holds its last value.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - In IDLE, if start and op_b==0, go directly to DONE. acc is still loaded, so DONE yields acc_in (MLA) or 0 (MUL), one cycle later.
  - In ITER, go to DONE after any edge where the shifted multiplier (mplier>>1) is 0.
  - Latency becomes 1 + index of the highest set bit of op_b + 1 cycles.
- Undefined: always W iterations; results are identical to the defined case.

Test Plan:
- MUL: op_a=7, op_b=6 -> done in cycle T+33 (feature off), mul_result=42, status_out N=0 Z=0 with C,V equal to status_in[2:1]; stall high for exactly 33 cycles.
- MLA: op_a=3, op_b=5, acc_in=10, is_mla=1 -> mul_result=25; alu_cmd=4'b0010 throughout ITER.
- Wrap/negative: op_a=32'hFFFFFFFF, op_b=2 -> mul_result=32'hFFFFFFFE, N=1, Z=0. With MUL_EARLY_TERM_EN, done arrives 3 cycles after T.
- Zero multiplier: op_b=0, MUL -> mul_result=0, Z=1. done at T+1 with MUL_EARLY_TERM_EN, T+33 without.
- Reset mid-op: rst asserted at iteration 10 -> next cycle stall=0, done=0, mul_result=0. A new start then completes correctly (e.g. 4*4=16).
- Idle pass-through: start=0, val1_in=0x11, val2_in=0x22, cmd_in=4'b0100 -> alu_in1=0x11, alu_in2=0x22, alu_cmd=4'b0100, stall=0. Toggling start during ITER changes nothing.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MUL/MLA sequencer that time-shares the EXE ALU adder for shift-and-add multiply.
// Optional early termination on an exhausted multiplier: define MUL_EARLY_TERM_EN.
module mul_seq_ctrl #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_mla,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic [W-1:0]     acc_in,
    input  logic [W-1:0]     val1_in,
    input  logic [W-1:0]     val2_in,
    input  logic [3:0]       cmd_in,
    input  logic [3:0]       status_in,
    input  logic [W-1:0]     alu_result,
    output logic [W-1:0]     alu_in1,
    output logic [W-1:0]     alu_in2,
    output logic [3:0]       alu_cmd,
    output logic             stall,
    output logic             done,
    output logic [W-1:0]     mul_result,
    output logic [3:0]       status_out
);

    localparam logic [3:0] CMD_ADD = 4'b0010;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [W-1:0]     acc, acc_next;
    logic [W-1:0]     mcand, mcand_next;
    logic [W-1:0]     mplier, mplier_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    // Next-state, datapath updates and ALU operand muxing
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        mcand_next  = mcand;
        mplier_next = mplier;
        cnt_next    = cnt;
        alu_in1     = val1_in;
        alu_in2     = val2_in;
        alu_cmd     = cmd_in;
        stall       = 1'b0;

        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    acc_next    = is_mla ? acc_in : '0;
                    mcand_next  = op_a;
                    mplier_next = op_b;
                    cnt_next    = '0;
`ifdef MUL_EARLY_TERM_EN
                    state_next  = (op_b == '0) ? DONE : ITER;
`else
                    state_next  = ITER;
`endif
                end
            end
            ITER: begin
                alu_in1     = acc;
                alu_in2     = mplier[0] ? mcand : '0;
                alu_cmd     = CMD_ADD;
                stall       = 1'b1;
                acc_next    = alu_result;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                cnt_next    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(W - 1)) begin
                    state_next = DONE;
                end
`ifdef MUL_EARLY_TERM_EN
                // No set bits left to add: remaining iterations would be no-ops
                else if ((mplier >> 1) == '0) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; product latched on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            mul_result <= '0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            cnt    <= cnt_next;
            done   <= (state_next == DONE);
            if (state_next == DONE) begin
                mul_result <= acc_next;
            end
        end
    end

    // Multiply updates N,Z only; flags pass through otherwise
    always_comb begin
        status_out = status_in;
        if (state == DONE) begin
            status_out = {acc[W-1], (acc == '0), status_in[2], status_in[1]};
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed cases plus randomized traffic vs. a behavioural model.
module tb_mul_seq_ctrl;

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_mla = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, acc_in = '0;
    logic [31:0] val1_in = '0, val2_in = '0;
    logic [3:0]  cmd_in = '0, status_in = '0;
    logic [31:0] alu_result;
    logic [31:0] alu_in1, alu_in2, mul_result;
    logic [3:0]  alu_cmd, status_out;
    logic        stall, done;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    // Shared ALU: adds for 0010, anything else gives a distinguishable value
    assign alu_result = (alu_cmd == 4'b0010) ? alu_in1 + alu_in2 : alu_in1 ^ alu_in2;

    mul_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .is_mla(is_mla),
        .op_a(op_a), .op_b(op_b), .acc_in(acc_in),
        .val1_in(val1_in), .val2_in(val2_in), .cmd_in(cmd_in),
        .status_in(status_in), .alu_result(alu_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd),
        .stall(stall), .done(done), .mul_result(mul_result),
        .status_out(status_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Cycles from the start-sampling cycle to the done cycle
    function automatic int lat_of(input logic [31:0] b);
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) if (b[i]) m = i;
        if (!EARLY) return 33;
        return (b == 32'd0) ? 1 : m + 2;
    endfunction

    // Behavioural model: m_ph = busy cycles still to run before the done cycle
    int          m_ph = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_done = 1'b0; m_res = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_prod = (is_mla ? acc_in : 32'd0) + op_a * op_b;
                if (lat_of(op_b) == 1) begin
                    m_done = 1'b1; m_res = m_prod;
                end else begin
                    m_ph = lat_of(op_b) - 1;
                end
            end
        end else begin
            m_ph = m_ph - 1;
            if (m_ph == 0) begin
                m_done = 1'b1; m_res = m_prod;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_done) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("product", mul_result, m_res);
                chk("status", 32'(status_out),
                    32'({m_res[31], m_res == 32'd0, status_in[2], status_in[1]}));
                chk("stall_done", 32'(stall), 32'd0);
                chk("pass_in1_done", alu_in1, val1_in);
                chk("pass_cmd_done", 32'(alu_cmd), 32'(cmd_in));
            end else begin
                chk("done_low", 32'(done), 32'd0);
                chk("result_hold", mul_result, m_res);
                if (m_ph != 0) begin
                    chk("stall_busy", 32'(stall), 32'd1);
                    chk("cmd_busy", 32'(alu_cmd), 32'h2);
                end else begin
                    chk("stall_idle", 32'(stall), 32'(start));
                    chk("pass_in1", alu_in1, val1_in);
                    chk("pass_in2", alu_in2, val2_in);
                    chk("pass_cmd", 32'(alu_cmd), 32'(cmd_in));
                end
            end
        end
    end

    // One directed operation with hand-computed expectations
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                         input logic mla, input bit tog, input logic [31:0] exp_res,
                         input int exp_lat, input logic [1:0] exp_nz);
        int n, sc;
        bit got;
        @(posedge clk); #1;
        op_a = a; op_b = b; acc_in = acc; is_mla = mla; status_in = 4'b0110; start = 1'b1;
        @(negedge clk);
        sc = int'(stall);
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; acc_in = $urandom;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else begin
                sc += int'(stall);
                @(posedge clk); #1;
                start = (tog && (n + 1 < exp_lat)) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        chk("op_timeout", 32'(got), 32'd1);
        chk("op_latency", 32'(n), 32'(exp_lat));
        chk("op_stall_cycles", 32'(sc), 32'(exp_lat));
        chk("op_result", mul_result, exp_res);
        chk("op_status", 32'(status_out), 32'({exp_nz, 2'b11}));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", mul_result, 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);

        @(posedge clk); #1;
        val1_in = 32'h11; val2_in = 32'h22; cmd_in = 4'b0100;
        @(negedge clk);
        chk("idle_in1", alu_in1, 32'h11);
        chk("idle_in2", alu_in2, 32'h22);
        chk("idle_cmd", 32'(alu_cmd), 32'h4);
        chk("idle_stall", 32'(stall), 32'd0);

        do_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 32'd42, EARLY ? 4 : 33, 2'b00);
        do_op(32'd3, 32'd5, 32'd10, 1'b1, 1'b0, 32'd25, EARLY ? 4 : 33, 2'b00);
        do_op(32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFE, EARLY ? 3 : 33, 2'b10);
        do_op(32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, EARLY ? 1 : 33, 2'b01);
        do_op(32'd5, 32'd0, 32'd77, 1'b1, 1'b0, 32'd77, EARLY ? 1 : 33, 2'b00);
        do_op(32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 32'd81, EARLY ? 5 : 33, 2'b00);

        // Abort a long multiply partway through
        @(posedge clk); #1;
        op_a = 32'd100; op_b = 32'h80000003; is_mla = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", mul_result, 32'd0);
        do_op(32'd4, 32'd4, 32'd0, 1'b0, 1'b0, 32'd16, EARLY ? 4 : 33, 2'b00);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst    = ($urandom_range(0, 299) == 0);
            start  = ($urandom_range(0, 3) == 0);
            is_mla = 1'($urandom);
            op_a   = $urandom;
            case ($urandom_range(0, 3))
                0:       op_b = 32'd0;
                1:       op_b = $urandom;
                default: op_b = $urandom >> $urandom_range(0, 31);
            endcase
            acc_in    = $urandom;
            val1_in   = $urandom;
            val2_in   = $urandom;
            cmd_in    = 4'($urandom);
            status_in = 4'($urandom);
        end
        @(posedge clk); #1 start = 1'b0; rst = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
